// File: rtl/uart_mem_cmd.sv
// UART byte-stream command engine: opcode/address/data bytes become memory word writes,
// or memory reads whose word is returned MSB first to the UART transmitter.
module uart_mem_cmd #(
  parameter int DATA_BYTES  = 2,
  parameter int ADDR_W      = 8,
  parameter int RD_LATENCY  = 1,
  parameter int TIMEOUT_CYC = 100000
) (
  input  logic                    clk_in,
  input  logic                    reset,
  input  logic                    data_rdy,
  input  logic [7:0]              data_in,
  output logic                    write_enable,
  output logic                    rd_en,
  output logic [ADDR_W-1:0]       addr,
  output logic [8*DATA_BYTES-1:0] data_out,
  input  logic [8*DATA_BYTES-1:0] rd_data,
  output logic                    tx_valid,
  output logic [7:0]              tx_data,
  input  logic                    tx_ready,
  output logic                    busy,
  output logic                    err
);

  localparam int W    = 8 * DATA_BYTES;
  localparam int TO_W = $clog2(TIMEOUT_CYC + 1);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    ADDR    = 3'd1,
    DATA    = 3'd2,
    WRITE   = 3'd3,
    RD_REQ  = 3'd4,
    RD_WAIT = 3'd5,
    TX      = 3'd6
  } state_t;

  state_t          state, state_nxt;
  logic            data_rdy_q;
  logic            accept;
  logic            is_rd;
  logic            in_cmd;
  logic            timeout;
  logic            in_engine;
  logic [2:0]      byte_cnt;
  logic [2:0]      lat_cnt;
  logic [TO_W-1:0] to_cnt;
  logic [W-1:0]    tx_shreg;

  assign accept    = data_rdy & ~data_rdy_q;
  assign in_cmd    = (state == ADDR) || (state == DATA);
  // An accepted byte always beats an expiring timeout in the same cycle.
  assign timeout   = in_cmd && !accept && (to_cnt == TO_W'(TIMEOUT_CYC - 1));
  assign in_engine = (state == WRITE) || (state == RD_REQ) || (state == RD_WAIT) || (state == TX);
  assign tx_data   = tx_shreg[W-1 -: 8];

  always_ff @(posedge clk_in) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt    = state;
    write_enable = 1'b0;
    rd_en        = 1'b0;
    tx_valid     = 1'b0;
    busy         = (state != IDLE);
    case (state)
      IDLE: begin
        if (accept && (data_in[7:4] == 4'h6 || data_in[7:4] == 4'h7)) state_nxt = ADDR;
      end
      ADDR: begin
        if (accept)       state_nxt = is_rd ? RD_REQ : DATA;
        else if (timeout) state_nxt = IDLE;
      end
      DATA: begin
        if (accept && byte_cnt == 3'(DATA_BYTES - 1)) state_nxt = WRITE;
        else if (timeout)                             state_nxt = IDLE;
      end
      WRITE: begin
        write_enable = 1'b1;
        state_nxt    = IDLE;
      end
      RD_REQ: begin
        rd_en     = 1'b1;
        state_nxt = RD_WAIT;
      end
      RD_WAIT: begin
        if (lat_cnt == 3'(RD_LATENCY - 1)) state_nxt = TX;
      end
      TX: begin
        tx_valid = 1'b1;
        if (tx_ready && byte_cnt == 3'(DATA_BYTES - 1)) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk_in) begin
    if (reset) begin
      data_rdy_q <= 1'b0;
      err        <= 1'b0;
      is_rd      <= 1'b0;
      addr       <= '0;
      data_out   <= '0;
      byte_cnt   <= '0;
      lat_cnt    <= '0;
      to_cnt     <= '0;
      tx_shreg   <= '0;
    end else begin
      data_rdy_q <= data_rdy;
      err        <= timeout | (accept & in_engine);
      if (accept || !in_cmd) to_cnt <= '0;
      else                   to_cnt <= to_cnt + TO_W'(1);
      case (state)
        IDLE: begin
          if (accept) is_rd <= data_in[4];
        end
        ADDR: begin
          if (accept) begin
            addr     <= data_in[ADDR_W-1:0];
            byte_cnt <= '0;
          end
        end
        DATA: begin
          if (accept) begin
            // Byte k lands in slice DATA_BYTES-1-k so the word fills MSB first.
            for (int i = 0; i < DATA_BYTES; i++) begin
              if (byte_cnt == 3'(DATA_BYTES - 1 - i)) data_out[8*i +: 8] <= data_in;
            end
            byte_cnt <= byte_cnt + 3'd1;
          end
        end
        RD_REQ: lat_cnt <= '0;
        RD_WAIT: begin
          lat_cnt <= lat_cnt + 3'd1;
          if (lat_cnt == 3'(RD_LATENCY - 1)) begin
            tx_shreg <= rd_data;
            byte_cnt <= '0;
          end
        end
        TX: begin
          if (tx_ready) begin
            tx_shreg <= tx_shreg << 8;
            byte_cnt <= byte_cnt + 3'd1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_mem_cmd.sv
// Directed bench: two instances (2-byte/8-bit-addr/latency 2 and 4-byte/3-bit-addr) on shared inputs.
module tb_uart_mem_cmd;

  logic        clk_in;
  logic        reset;
  logic        data_rdy;
  logic [7:0]  data_in;
  logic        tx_ready;

  logic        write_enable, rd_en, tx_valid, busy, err;
  logic [7:0]  addr, tx_data;
  logic [15:0] data_out, rd_data;

  logic        write_enable2, rd_en2, tx_valid2, busy2, err2;
  logic [2:0]  addr2;
  logic [7:0]  tx_data2;
  logic [31:0] data_out2, rd_data2;

  int n_tests, n_fail;
  int we_cnt, rd_cnt, err_cnt, we2_cnt;
  int we_base, err_base, we2_base;
  logic mem_v1, mem_v2;

  uart_mem_cmd #(.DATA_BYTES(2), .ADDR_W(8), .RD_LATENCY(2), .TIMEOUT_CYC(10)) dut (
    .clk_in(clk_in), .reset(reset), .data_rdy(data_rdy), .data_in(data_in),
    .write_enable(write_enable), .rd_en(rd_en), .addr(addr), .data_out(data_out),
    .rd_data(rd_data), .tx_valid(tx_valid), .tx_data(tx_data), .tx_ready(tx_ready),
    .busy(busy), .err(err)
  );

  uart_mem_cmd #(.DATA_BYTES(4), .ADDR_W(3), .RD_LATENCY(1), .TIMEOUT_CYC(10)) dut2 (
    .clk_in(clk_in), .reset(reset), .data_rdy(data_rdy), .data_in(data_in),
    .write_enable(write_enable2), .rd_en(rd_en2), .addr(addr2), .data_out(data_out2),
    .rd_data(rd_data2), .tx_valid(tx_valid2), .tx_data(tx_data2), .tx_ready(tx_ready),
    .busy(busy2), .err(err2)
  );

  initial clk_in = 1'b0;
  always #5 clk_in = ~clk_in;

  // Two-cycle memory: data is only valid in the cycle RD_LATENCY after rd_en.
  always @(posedge clk_in) begin
    mem_v1 <= rd_en;
    mem_v2 <= mem_v1;
  end
  assign rd_data  = mem_v2 ? 16'hABCD : 16'h0000;
  assign rd_data2 = 32'h0;

  always @(negedge clk_in) begin
    if (write_enable)  we_cnt++;
    if (rd_en)         rd_cnt++;
    if (err)           err_cnt++;
    if (write_enable2) we2_cnt++;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic send_byte(input logic [7:0] b);
    @(negedge clk_in);
    data_in  = b;
    data_rdy = 1'b1;
    @(negedge clk_in);
    data_rdy = 1'b0;
  endtask

  task automatic send_write(input logic [7:0] a, input logic [7:0] d1, input logic [7:0] d0);
    send_byte(8'h60);
    send_byte(a);
    send_byte(d1);
    send_byte(d0);
  endtask

  initial begin
    n_tests = 0; n_fail = 0;
    we_cnt = 0; rd_cnt = 0; err_cnt = 0; we2_cnt = 0;
    mem_v1 = 1'b0; mem_v2 = 1'b0;
    reset = 1'b1; data_rdy = 1'b0; data_in = 8'h00; tx_ready = 1'b0;
    repeat (3) @(negedge clk_in);

    check("rst_we",   write_enable, 0);
    check("rst_rd",   rd_en, 0);
    check("rst_txv",  tx_valid, 0);
    check("rst_busy", busy, 0);
    check("rst_err",  err, 0);
    check("rst_addr", addr, 0);
    check("rst_dout", data_out, 0);
    check("rst_txd",  tx_data, 0);

    // data_rdy already high when reset releases counts as a fresh opcode byte
    data_in = 8'h60; data_rdy = 1'b1;
    @(negedge clk_in);
    reset = 1'b0;
    @(negedge clk_in);
    check("rdy_at_release_busy", busy, 1);
    data_rdy = 1'b0;
    send_byte(8'h09); send_byte(8'hAA); send_byte(8'h55);
    check("rel_we",   write_enable, 1);
    check("rel_addr", addr, 8'h09);
    check("rel_dout", data_out, 16'hAA55);

    // basic write
    send_write(8'h05, 8'hAB, 8'hCD);
    check("wr_we",   write_enable, 1);
    check("wr_addr", addr, 8'h05);
    check("wr_dout", data_out, 16'hABCD);
    @(negedge clk_in);
    check("wr_we_off", write_enable, 0);
    check("wr_busy",   busy, 0);
    check("wr_count",  we_cnt, 2);

    // garbage in IDLE
    err_base = err_cnt; we_base = we_cnt;
    send_byte(8'h12); send_byte(8'hFF);
    @(negedge clk_in);
    check("garb_err",  err_cnt, err_base);
    check("garb_we",   we_cnt, we_base);
    check("garb_busy", busy, 0);
    send_write(8'h3C, 8'h12, 8'h34);
    check("garb_wr_we",   write_enable, 1);
    check("garb_wr_addr", addr, 8'h3C);
    check("garb_wr_dout", data_out, 16'h1234);

    // read with back-pressure on the first TX byte
    send_byte(8'h70); send_byte(8'h05);
    check("rd_en_lat", rd_en, 1);
    @(negedge clk_in);
    check("rd_en_off", rd_en, 0);
    check("rd_txv_early", tx_valid, 0);
    @(negedge clk_in);
    check("rd_txv_early2", tx_valid, 0);
    @(negedge clk_in);
    check("rd_txv", tx_valid, 1);
    check("rd_tx0", tx_data, 8'hAB);
    @(negedge clk_in);
    check("rd_hold1", tx_data, 8'hAB);
    @(negedge clk_in);
    check("rd_hold2", tx_data, 8'hAB);
    check("rd_hold2_v", tx_valid, 1);
    tx_ready = 1'b1;
    @(negedge clk_in);
    check("rd_tx1", tx_data, 8'hCD);
    check("rd_tx1_v", tx_valid, 1);
    @(negedge clk_in);
    check("rd_done_v", tx_valid, 0);
    check("rd_done_busy", busy, 0);
    check("rd_count", rd_cnt, 1);
    tx_ready = 1'b0;

    // timeout mid-write
    we_base = we_cnt; err_base = err_cnt;
    send_byte(8'h60); send_byte(8'h01); send_byte(8'h11);
    repeat (9) @(negedge clk_in);
    check("to_err_early", err, 0);
    check("to_busy_early", busy, 1);
    @(negedge clk_in);
    check("to_err", err, 1);
    check("to_idle", busy, 0);
    @(negedge clk_in);
    check("to_err_pulse", err, 0);
    check("to_no_we", we_cnt, we_base);
    check("to_err_cnt", err_cnt, err_base + 1);
    check("to_partial", data_out, 16'h1134);

    // byte arriving TIMEOUT_CYC-1 cycles after the previous is still valid
    err_base = err_cnt;
    send_byte(8'h60); send_byte(8'h02);
    repeat (7) @(negedge clk_in);
    send_byte(8'h55); send_byte(8'h66);
    check("tob_we",   write_enable, 1);
    check("tob_addr", addr, 8'h02);
    check("tob_dout", data_out, 16'h5566);
    check("tob_noerr", err_cnt, err_base);

    // opcode byte during TX is dropped with an error
    err_base = err_cnt;
    send_byte(8'h70); send_byte(8'h05);
    repeat (2) @(negedge clk_in);
    send_byte(8'h60);
    check("txe_err", err, 1);
    check("txe_txv", tx_valid, 1);
    check("txe_tx0", tx_data, 8'hAB);
    tx_ready = 1'b1;
    @(negedge clk_in);
    check("txe_tx1", tx_data, 8'hCD);
    @(negedge clk_in);
    check("txe_done", busy, 0);
    check("txe_err_cnt", err_cnt, err_base + 1);
    tx_ready = 1'b0;

    // reset mid-command
    we_base = we_cnt;
    send_byte(8'h60); send_byte(8'h07); send_byte(8'hAA);
    reset = 1'b1;
    @(negedge clk_in);
    check("mrst_busy", busy, 0);
    check("mrst_addr", addr, 0);
    check("mrst_dout", data_out, 0);
    check("mrst_err",  err, 0);
    check("mrst_txd",  tx_data, 0);
    reset = 1'b0;
    send_byte(8'hBB);
    @(negedge clk_in);
    check("mrst_no_we", we_cnt, we_base);
    check("mrst_idle",  busy, 0);
    send_write(8'h08, 8'h12, 8'h34);
    check("mrst_wr_we",   write_enable, 1);
    check("mrst_wr_addr", addr, 8'h08);
    check("mrst_wr_dout", data_out, 16'h1234);

    // 4-byte word, 3-bit address
    reset = 1'b1;
    @(negedge clk_in);
    reset = 1'b0;
    we2_base = we2_cnt;
    send_byte(8'h60); send_byte(8'hFF); send_byte(8'h01); send_byte(8'h02);
    reset = 1'b1;
    @(negedge clk_in);
    check("w4_rst_busy", busy2, 0);
    check("w4_rst_addr", addr2, 0);
    check("w4_rst_dout", data_out2, 0);
    reset = 1'b0;
    send_byte(8'h60); send_byte(8'hFF);
    send_byte(8'h11); send_byte(8'h22); send_byte(8'h33); send_byte(8'h44);
    check("w4_we",   write_enable2, 1);
    check("w4_addr", addr2, 3'h7);
    check("w4_dout", data_out2, 32'h11223344);
    @(negedge clk_in);
    check("w4_count", we2_cnt, we2_base + 1);
    check("w4_idle",  busy2, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/uart_mem_cmd.md
# uart_mem_cmd

Parametrised UART-facing memory command engine: decodes byte streams from the UART receiver into word writes and word reads on a single-port register/memory array, and returns read data to the UART transmitter. Generalises the single-word, 4-bit-address write-only controller to configurable word width, address width and read latency. Adds read-back, an inter-byte timeout and error reporting. Sits between `uart_rx`/`uart_tx` and the PID coefficient/setpoint memory.

## Interface
- `DATA_BYTES`, 2: bytes per memory word; word width = 8*DATA_BYTES, range 1..4.
- `ADDR_W`, 8: address width, range 1..8; taken from the low ADDR_W bits of the address byte.
- `RD_LATENCY`, 1: cycles from `rd_en` to valid `rd_data`, range 1..4.
- `TIMEOUT_CYC`, 100000: maximum clk_in cycles between bytes of one command, >=2.
- `clk_in` in 1: single clock.
- `reset` in 1: synchronous, active-high.
- `data_rdy` in 1: UART RX byte-ready level; a rising edge marks a new byte.
- `data_in` in 8: UART RX byte; stable while `data_rdy` high.
- `write_enable` out 1: one-cycle memory write strobe.
- `rd_en` out 1: one-cycle memory read strobe.
- `addr` out ADDR_W: memory address.
- `data_out` out 8*DATA_BYTES: write data.
- `rd_data` in 8*DATA_BYTES: read data from memory.
- `tx_valid` out 1: byte available for UART TX.
- `tx_data` out 8: byte to UART TX.
- `tx_ready` in 1: UART TX accepts byte when `tx_valid && tx_ready`.
- `busy` out 1: high in every state except IDLE.
- `err` out 1: one-cycle error pulse.

## Operation
- Byte accept: internal registered edge detect; byte accepted in the first cycle `data_rdy` is sampled high after being sampled low. Only accepted bytes advance the FSM.
- Command format: opcode byte (`[7:4]`: 0x6 write, 0x7 read; `[3:0]` ignored), then address byte, then for write DATA_BYTES data bytes, MSB first.
- States: IDLE, ADDR, DATA, WRITE, RD_REQ, RD_WAIT, TX.
- IDLE: 0x6 -> ADDR (op=write); 0x7 -> ADDR (op=read); any other byte ignored, no `err`.
- ADDR: accepted byte -> `addr` <= byte[ADDR_W-1:0]; write -> DATA, byte count 0; read -> RD_REQ.
- DATA: each byte loads `data_out` slice `[8*(DATA_BYTES-k)-1 -: 8]` for byte k. After byte DATA_BYTES-1 -> WRITE.
- WRITE: `write_enable`=1 for exactly this cycle -> IDLE.
- RD_REQ: `rd_en`=1 for exactly this cycle -> RD_WAIT.
- RD_WAIT: count RD_LATENCY cycles. Then capture `rd_data` into a shift register -> TX.
- TX: present bytes MSB first on `tx_data` with `tx_valid`=1. Advance on `tx_valid && tx_ready`. After the last handshake -> IDLE, `tx_valid`=0.
- Timeout: in ADDR/DATA, cycle counter resets on each accepted byte. Reaching TIMEOUT_CYC -> pulse `err`, go to IDLE. No write is issued; `data_out` keeps the partial contents.
- Bytes accepted in WRITE/RD_REQ/RD_WAIT/TX are dropped with an `err` pulse; the FSM is not disturbed.
- `addr` and `data_out` hold their last values outside commands.

## Timing
- Reset (synchronous): state IDLE. `write_enable`, `rd_en`, `tx_valid`, `err`, `busy` = 0; `addr`, `data_out`, `tx_data` = 0; counters = 0. Edge detector history = 0, so a `data_rdy` already high at reset release counts as a new byte.
- Reset asserted mid-command wins over everything. Outputs take reset values on the next edge, and no `write_enable` or `rd_en` is issued for the aborted command.
- Write latency: `write_enable` high exactly 1 cycle after the cycle the last data byte is accepted. `addr` and `data_out` are valid that cycle.
- Read latency: `rd_en` high 1 cycle after the address byte is accepted. `rd_data` is sampled RD_LATENCY cycles after the `rd_en` cycle. First `tx_valid` is asserted the following cycle.
- `tx_data` and `tx_valid` are stable while `tx_ready`=0.
- Timeout boundary: a byte accepted on cycle TIMEOUT_CYC-1 after the previous one is valid. At TIMEOUT_CYC with no byte, the command is aborted.
- A timeout and a byte accept in the same cycle: the byte wins.

## Test plan
- DATA_BYTES=2: bytes 0x60, 0x05, 0xAB, 0xCD -> one `write_enable` pulse with `addr`=0x05, `data_out`=0xABCD; `busy` low the next cycle.
- Read, RD_LATENCY=2: 0x70, 0x05, with memory returning 0xABCD -> `rd_en` 1 cycle after the address byte; TX emits 0xAB then 0xCD. Hold `tx_ready`=0 for 3 cycles on the first byte -> `tx_data` stays 0xAB.
- Garbage in IDLE: 0x12, 0xFF -> no strobes, no `err`; a following valid write completes normally.
- Timeout, TIMEOUT_CYC=10: 0x60, 0x01, 0x11, then silence -> `err` pulse 10 cycles after 0x11, no `write_enable`, FSM in IDLE.
- Byte 0x60 arriving during TX -> `err` pulse; TX sequence completes unchanged.
- Reset asserted between the second and last data byte -> no `write_enable`; all outputs 0; the next full write works. Repeat with DATA_BYTES=4 and ADDR_W=3, address byte 0xFF -> `addr`=7.
